// File: rtl/hx8352_init_seq_pkg.sv
// Shared definitions for the HX8352 panel init sequencer.
// Holds the init-table entry layout {op[1:0], arg[15:0]}, the opcode encodings,
// the sequencer state encodings and a small helper that packs a table entry.
package hx8352_init_seq_pkg;

  localparam int unsigned EntryW = 18;

  // Opcode of a table entry; bit 0 doubles as the LCD RS level for CMD/DATA.
  typedef enum logic [1:0] {
    OpCmd   = 2'd0,
    OpData  = 2'd1,
    OpDelay = 2'd2,
    OpEnd   = 2'd3
  } op_e;

  typedef enum logic [2:0] {
    StIdle     = 3'd0,
    StFetch    = 3'd1,
    StBusReq   = 3'd2,
    StDlyStart = 3'd3,
    StDlyWait  = 3'd4,
    StFinish   = 3'd5
  } state_e;

  function automatic logic [EntryW-1:0] mk_entry(op_e op, logic [15:0] arg);
    return {op, arg};
  endfunction

endpackage

// File: rtl/hx8352_init_rom.sv
// Combinational init table for the HX8352 sequencer.
// Ports:
//   addr  - table index (ROM_AW bits)
//   entry - {op[1:0], arg[15:0]} at that index
// TABLE_ID selects the table image:
//   0 - panel bring-up table (CMD/DATA pairs around a 10 ms settle delay)
//   1 - full-depth image with no END entry, a zero delay at 5 and a short
//       delay at 10, used to exercise end-of-table handling
module hx8352_init_rom
  import hx8352_init_seq_pkg::*;
#(
  parameter int unsigned ROM_AW   = 6,
  parameter int unsigned TABLE_ID = 0
) (
  input  logic [ROM_AW-1:0] addr,
  output logic [EntryW-1:0] entry
);

  always_comb begin
    entry = mk_entry(OpEnd, 16'h0000);
    if (TABLE_ID == 0) begin
      case (int'(addr))
        0:       entry = mk_entry(OpCmd,   16'h0083);
        1:       entry = mk_entry(OpData,  16'h0002);
        2:       entry = mk_entry(OpDelay, 16'd10000);
        3:       entry = mk_entry(OpCmd,   16'h0085);
        4:       entry = mk_entry(OpData,  16'h0003);
        default: entry = mk_entry(OpEnd,   16'h0000);
      endcase
    end else begin
      if (int'(addr) == 5) begin
        entry = mk_entry(OpDelay, 16'd0);
      end else if (int'(addr) == 10) begin
        entry = mk_entry(OpDelay, 16'd3);
      end else begin
        entry = mk_entry(addr[0] ? OpData : OpCmd, 16'h1000 + 16'(addr));
      end
    end
  end

endmodule

// File: rtl/hx8352_init_seq.sv
// HX8352 LCD controller init sequencer.
// Walks the init table from entry 0, issuing register index/data writes to the
// bus writer and timed waits to the delay unit, until an END entry or the last
// table slot has executed.
// Ports:
//   clk_1MHz   - 1 MHz system clock
//   rst        - asynchronous active-high reset
//   start      - begin a sequence (only honoured when idle)
//   busy       - sequence in progress
//   done       - level, set when a sequence ends, cleared on the next start
//   bus_req    - write request; bus_rs/bus_data held until bus_ack
//   bus_rs     - 0 = register index, 1 = register data
//   bus_data   - write word
//   bus_ack    - bus writer accepted the word
//   delay_step - one-cycle pulse launching a delay of delay_us microseconds
//   delay_us   - delay length, held from delay_step until delay_done
//   delay_done - delay unit finished
module hx8352_init_seq
  import hx8352_init_seq_pkg::*;
#(
  parameter int unsigned ROM_AW   = 6,
  parameter int unsigned TABLE_ID = 0
) (
  input  logic        clk_1MHz,
  input  logic        rst,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic        bus_req,
  output logic        bus_rs,
  output logic [15:0] bus_data,
  input  logic        bus_ack,
  output logic        delay_step,
  output logic [15:0] delay_us,
  input  logic        delay_done
);

  localparam logic [ROM_AW-1:0] PcLast = '1;

  state_e              state_q, state_d;
  logic [ROM_AW-1:0]   pc_q, pc_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                bus_req_q, bus_req_d;
  logic                bus_rs_q, bus_rs_d;
  logic [15:0]         bus_data_q, bus_data_d;
  logic                delay_step_q, delay_step_d;
  logic [15:0]         delay_us_q, delay_us_d;
  logic                dly_first_q, dly_first_d;

  logic [EntryW-1:0]   entry;
  op_e                 op;
  logic [15:0]         arg;
  logic                pc_last;

  hx8352_init_rom #(
    .ROM_AW   (ROM_AW),
    .TABLE_ID (TABLE_ID)
  ) u_rom (
    .addr  (pc_q),
    .entry (entry)
  );

  assign op      = op_e'(entry[EntryW-1:EntryW-2]);
  assign arg     = entry[15:0];
  // The last slot acts as an implicit END once executed; pc never wraps.
  assign pc_last = (pc_q == PcLast);

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    busy_d       = busy_q;
    done_d       = done_q;
    bus_req_d    = bus_req_q;
    bus_rs_d     = bus_rs_q;
    bus_data_d   = bus_data_q;
    delay_step_d = 1'b0;
    delay_us_d   = delay_us_q;
    dly_first_d  = dly_first_q;

    case (state_q)
      StIdle: begin
        if (start) begin
          pc_d    = '0;
          done_d  = 1'b0;
          busy_d  = 1'b1;
          state_d = StFetch;
        end
      end

      StFetch: begin
        case (op)
          OpCmd, OpData: begin
            bus_req_d  = 1'b1;
            bus_rs_d   = entry[16];
            bus_data_d = arg;
            state_d    = StBusReq;
          end
          OpDelay: begin
            if (arg != 16'd0) begin
              delay_step_d = 1'b1;
              delay_us_d   = arg;
              state_d      = StDlyStart;
            end else if (pc_last) begin
              state_d = StFinish;
            end else begin
              pc_d = pc_q + 1'b1;
            end
          end
          default: state_d = StFinish;
        endcase
      end

      StBusReq: begin
        if (bus_ack && bus_req_q) begin
          bus_req_d = 1'b0;
          if (pc_last) begin
            state_d = StFinish;
          end else begin
            pc_d    = pc_q + 1'b1;
            state_d = StFetch;
          end
        end
      end

      StDlyStart: begin
        dly_first_d = 1'b1;
        state_d     = StDlyWait;
      end

      StDlyWait: begin
        // First cycle skipped so a done left over from a prior delay is not taken.
        if (dly_first_q) begin
          dly_first_d = 1'b0;
        end else if (delay_done) begin
          if (pc_last) begin
            state_d = StFinish;
          end else begin
            pc_d    = pc_q + 1'b1;
            state_d = StFetch;
          end
        end
      end

      StFinish: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = StIdle;
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_1MHz or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      pc_q         <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      bus_req_q    <= 1'b0;
      bus_rs_q     <= 1'b0;
      bus_data_q   <= 16'h0000;
      delay_step_q <= 1'b0;
      delay_us_q   <= 16'h0000;
      dly_first_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      bus_req_q    <= bus_req_d;
      bus_rs_q     <= bus_rs_d;
      bus_data_q   <= bus_data_d;
      delay_step_q <= delay_step_d;
      delay_us_q   <= delay_us_d;
      dly_first_q  <= dly_first_d;
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign bus_req    = bus_req_q;
  assign bus_rs     = bus_rs_q;
  assign bus_data   = bus_data_q;
  assign delay_step = delay_step_q;
  assign delay_us   = delay_us_q;

endmodule

// File: tb/tb_hx8352_init_seq.sv
// Bench for hx8352_init_seq. Instance 0 uses the bring-up table, instance 1 the
// full-depth table without END. Stimulus pushes the expected event trace
// (writes, delay launches, end) into a per-instance queue; a monitor pops and
// compares whenever the DUT presents a write, a delay_step or a rising done.
module tb_hx8352_init_seq;
  import hx8352_init_seq_pkg::*;

  typedef struct packed {
    logic [1:0]  kind;   // 0 index write, 1 data write, 2 delay, 3 end
    logic [15:0] val;
  } exp_t;

  localparam int DlyCycles = 5;

  logic        clk = 1'b0;
  logic        rst;
  logic        start      [2];
  logic        busy       [2];
  logic        done       [2];
  logic        bus_req    [2];
  logic        bus_rs     [2];
  logic [15:0] bus_data   [2];
  logic        bus_ack    [2];
  logic        delay_step [2];
  logic [15:0] delay_us   [2];
  logic        delay_done [2];

  exp_t sb [2][$];
  int   checks   = 0;
  int   failures = 0;
  int   ack_lat  [2];
  bit   ack_en   [2];
  int   ack_cnt  [2];
  bit   dly_run  [2];
  int   dly_cnt  [2];
  bit   done_prev[2];
  bit   req_prev [2];
  int   gap      [2];
  bit   gap_seen = 1'b0;

  always #5 clk = ~clk;

  hx8352_init_seq #(.ROM_AW(6), .TABLE_ID(0)) dut0 (
    .clk_1MHz   (clk),
    .rst        (rst),
    .start      (start[0]),
    .busy       (busy[0]),
    .done       (done[0]),
    .bus_req    (bus_req[0]),
    .bus_rs     (bus_rs[0]),
    .bus_data   (bus_data[0]),
    .bus_ack    (bus_ack[0]),
    .delay_step (delay_step[0]),
    .delay_us   (delay_us[0]),
    .delay_done (delay_done[0])
  );

  hx8352_init_seq #(.ROM_AW(6), .TABLE_ID(1)) dut1 (
    .clk_1MHz   (clk),
    .rst        (rst),
    .start      (start[1]),
    .busy       (busy[1]),
    .done       (done[1]),
    .bus_req    (bus_req[1]),
    .bus_rs     (bus_rs[1]),
    .bus_data   (bus_data[1]),
    .bus_ack    (bus_ack[1]),
    .delay_step (delay_step[1]),
    .delay_us   (delay_us[1]),
    .delay_done (delay_done[1])
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push(input int k, input logic [1:0] kind, input logic [15:0] val);
    exp_t e;
    e.kind = kind;
    e.val  = val;
    sb[k].push_back(e);
  endtask

  task automatic push_table0();
    push(0, 2'd0, 16'h0083);
    push(0, 2'd1, 16'h0002);
    push(0, 2'd2, 16'd10000);
    push(0, 2'd0, 16'h0085);
    push(0, 2'd1, 16'h0003);
    push(0, 2'd3, 16'h0000);
  endtask

  task automatic pulse_start(input int k);
    @(negedge clk);
    start[k] = 1'b1;
    @(negedge clk);
    start[k] = 1'b0;
  endtask

  task automatic wait_done(input int k, input int budget);
    int n = 0;
    while (!done[k] && n < budget) begin
      @(negedge clk);
      n++;
    end
    check($sformatf("done_in_time%0d", k), 64'(n < budget), 64'd1);
    @(negedge clk);
  endtask

  task automatic check_reset_outputs(input int k, input string name);
    check(name, {27'd0, busy[k], done[k], bus_req[k], bus_rs[k], delay_step[k],
                 bus_data[k], delay_us[k]}, 64'd0);
  endtask

  // Bus writer / delay unit models followed by the scoreboard monitor; one
  // process so the ack decision and the transfer check see the same values.
  initial begin
    for (int k = 0; k < 2; k++) begin
      bus_ack[k] = 1'b0; delay_done[k] = 1'b0; ack_cnt[k] = 0; dly_run[k] = 1'b0;
      dly_cnt[k] = 0; done_prev[k] = 1'b0; req_prev[k] = 1'b0; gap[k] = 0;
    end
    forever begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        if (rst) begin
          bus_ack[k] = 1'b0; delay_done[k] = 1'b0; ack_cnt[k] = 0; dly_run[k] = 1'b0;
          done_prev[k] = 1'b0; req_prev[k] = 1'b0; gap[k] = 0;
        end else begin
          if (bus_ack[k]) begin
            bus_ack[k] = 1'b0;
          end else if (bus_req[k] && ack_en[k]) begin
            ack_cnt[k]++;
            if (ack_cnt[k] >= ack_lat[k]) begin
              bus_ack[k] = 1'b1;
              ack_cnt[k] = 0;
            end
          end else begin
            ack_cnt[k] = 0;
          end
          if (delay_done[k]) begin
            delay_done[k] = 1'b0;
          end else if (delay_step[k]) begin
            dly_run[k] = 1'b1;
            dly_cnt[k] = 0;
          end else if (dly_run[k]) begin
            dly_cnt[k]++;
            if (dly_cnt[k] >= DlyCycles) begin
              delay_done[k] = 1'b1;
              dly_run[k]    = 1'b0;
            end
          end

          if (bus_req[k]) begin
            if (k == 1 && !req_prev[k] && sb[k].size() > 0 && sb[k][0].val == 16'h1006) begin
              check("delay0_gap", 64'(gap[k]), 64'd2);
              gap_seen = 1'b1;
            end
            gap[k] = 0;
            check($sformatf("write_pending%0d", k), 64'(sb[k].size() > 0), 64'd1);
            if (sb[k].size() > 0) begin
              check($sformatf("write_word%0d", k), {46'd0, 1'b0, bus_rs[k], bus_data[k]},
                    {46'd0, sb[k][0].kind, sb[k][0].val});
              if (bus_ack[k]) void'(sb[k].pop_front());
            end
          end else begin
            gap[k]++;
          end
          req_prev[k] = bus_req[k];

          if (delay_step[k]) begin
            check($sformatf("delay_pending%0d", k), 64'(sb[k].size() > 0), 64'd1);
            if (sb[k].size() > 0) begin
              check($sformatf("delay_step%0d", k), {46'd0, 2'd2, delay_us[k]},
                    {46'd0, sb[k][0].kind, sb[k][0].val});
              void'(sb[k].pop_front());
            end
          end

          if (done[k] && !done_prev[k]) begin
            check($sformatf("end_pending%0d", k), 64'(sb[k].size() > 0), 64'd1);
            if (sb[k].size() > 0) begin
              check($sformatf("end_event%0d", k), {46'd0, 2'd3, 16'd0},
                    {46'd0, sb[k][0].kind, sb[k][0].val});
              void'(sb[k].pop_front());
            end
          end
          done_prev[k] = done[k];
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1);
  end

  initial begin
    int n;
    rst = 1'b1;
    for (int k = 0; k < 2; k++) begin
      start[k]  = 1'b0;
      ack_en[k] = 1'b1;
    end
    ack_lat[0] = 2;
    ack_lat[1] = 1;
    repeat (3) @(negedge clk);
    check_reset_outputs(0, "reset_outputs0");
    check_reset_outputs(1, "reset_outputs1");
    rst = 1'b0;

    // Bring-up table, ack two cycles after req, stray start while busy.
    push_table0();
    pulse_start(0);
    check("busy_after_start", 64'(busy[0]), 64'd1);
    repeat (3) @(negedge clk);
    pulse_start(0);
    wait_done(0, 300);
    check("run1_done_busy", {62'd0, done[0], busy[0]}, 64'd2);
    check("run1_trace_left", 64'(sb[0].size()), 64'd0);

    // Second start clears done and replays the same trace.
    push_table0();
    pulse_start(0);
    check("run2_done_cleared", {62'd0, done[0], busy[0]}, 64'd1);
    wait_done(0, 300);
    check("run2_done_busy", {62'd0, done[0], busy[0]}, 64'd2);
    check("run2_trace_left", 64'(sb[0].size()), 64'd0);

    // Ack withheld for 100 cycles: the monitor re-checks the held word each cycle.
    ack_en[0] = 1'b0;
    push_table0();
    pulse_start(0);
    repeat (100) @(negedge clk);
    check("hold_req", 64'(bus_req[0]), 64'd1);
    check("hold_pc", 64'(dut0.pc_q), 64'd0);
    check("hold_trace_left", 64'(sb[0].size()), 64'd6);
    ack_en[0] = 1'b1;
    wait_done(0, 300);
    check("hold_trace_done", 64'(sb[0].size()), 64'd0);

    // Reset while waiting on the delay, then a clean restart from entry 0.
    push_table0();
    pulse_start(0);
    n = 0;
    while (!delay_step[0] && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("delay_step_seen", 64'(n < 100), 64'd1);
    repeat (2) @(negedge clk);
    check("in_dly_wait", 64'(dut0.state_q), 64'(StDlyWait));
    #1 rst = 1'b1;
    #1;
    check_reset_outputs(0, "midrun_reset_outputs");
    check("midrun_reset_state", 64'(dut0.state_q), 64'(StIdle));
    check("midrun_reset_pc", 64'(dut0.pc_q), 64'd0);
    sb[0].delete();
    @(negedge clk);
    #1 rst = 1'b0;
    repeat (3) @(negedge clk);
    check("no_resume", 64'(busy[0]), 64'd0);
    push_table0();
    pulse_start(0);
    wait_done(0, 300);
    check("restart_trace_left", 64'(sb[0].size()), 64'd0);

    // Full-depth table with no END: 64 entries, then done, no wrap.
    for (int i = 0; i < 64; i++) begin
      if (i == 10) push(1, 2'd2, 16'd3);
      else if (i != 5) push(1, (i % 2 == 1) ? 2'd1 : 2'd0, 16'h1000 + 16'(i));
    end
    push(1, 2'd3, 16'h0000);
    pulse_start(1);
    wait_done(1, 1000);
    repeat (10) @(negedge clk);
    check("noend_idle", {61'd0, bus_req[1], busy[1], done[1]}, 64'd1);
    check("noend_pc", 64'(dut1.pc_q), 64'd63);
    check("noend_trace_left", 64'(sb[1].size()), 64'd0);
    check("delay0_gap_seen", 64'(gap_seen), 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/hx8352_init_seq.md
HX8352_INIT_SEQ -- requirements
Module: hx8352_init_seq

Interface
REQ-001 SHALL have parameter ROM_AW, default 6, meaning the init table address width (64 entries).
REQ-002 SHALL have port clk_1MHz  input  1  system clock, 1 MHz; the only clock.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port start  input  1  begin the init sequence; sampled only in IDLE.
REQ-005 SHALL have port busy  output  1  high from the cycle after start is accepted until the sequence ends.
REQ-006 SHALL have port done  output  1  level, set on sequence end, cleared when the next start is accepted.
REQ-007 SHALL have port bus_req  output  1  LCD write request to the bus writer.
REQ-008 SHALL have port bus_rs  output  1  0 = register index, 1 = register data.
REQ-009 SHALL have port bus_data  output  16  write word.
REQ-010 SHALL have port bus_ack  input  1  bus writer accepted the word.
REQ-011 SHALL have port delay_step  output  1  one-cycle pulse starting hx8352_delay_us.
REQ-012 SHALL have port delay_us  output  16  delay length in µs, stable from the delay_step cycle until delay_done.
REQ-013 SHALL have port delay_done  input  1  delay complete, from hx8352_delay_us.

Function
REQ-014 SHALL read 18-bit entries {op[1:0], arg[15:0]}: op CMD=0, DATA=1, DELAY=2, END=3.
REQ-015 SHALL implement states IDLE, FETCH, BUS_REQ, DLY_START, DLY_WAIT, FINISH.
REQ-016 SHALL leave IDLE when start=1: pc<=0, done<=0, busy<=1, next state FETCH.
REQ-017 SHALL decode the entry at pc in FETCH: CMD/DATA->BUS_REQ; DELAY with arg!=0->DLY_START; DELAY with arg=0->pc+1 and stay in FETCH; END->FINISH.
REQ-018 SHALL, in BUS_REQ, hold bus_req=1, bus_rs=op[0] and bus_data=arg stable until bus_ack=1 is sampled.
REQ-019 SHALL, on the ack cycle, drop bus_req in the next cycle, increment pc and return to FETCH; an ack while bus_req=0 SHALL be ignored.
REQ-020 SHALL, in DLY_START, drive delay_us=arg and delay_step=1 for exactly one cycle, then go to DLY_WAIT.
REQ-021 SHALL, in DLY_WAIT, ignore delay_done in the first cycle (clears stale done), then on delay_done=1 increment pc and go to FETCH.
REQ-022 SHALL, in FINISH, set done=1 and busy=0 and return to IDLE in one cycle.
REQ-023 SHALL treat pc reaching 2^ROM_AW-1 without END as END: that entry is executed, then FINISH; pc SHALL never wrap.
REQ-024 SHALL ignore start while busy=1.
REQ-025 SHALL start a new run if start=1 arrives in the same cycle as FINISH completes only when the FSM is back in IDLE, i.e. one cycle later.
REQ-026 SHALL incur latency of 1 cycle FETCH plus the handshake duration per entry; minimum 3 cycles per CMD/DATA entry with immediate ack.

Reset
REQ-027 SHALL, on rst=1 at any time including mid-sequence, immediately set state=IDLE, pc=0, busy=0, done=0, bus_req=0, bus_rs=0, bus_data=0, delay_step=0, delay_us=0.
REQ-028 SHALL resume only on a new start after rst deasserts; a partial sequence is not resumed.

Structure
REQ-029 SHALL place the opcode constants, entry width (18) and state encodings in shared include hx8352_defs.vh.
REQ-030 SHALL place the init table in a sub-module hx8352_init_rom (input addr[ROM_AW-1:0], output entry[17:0], combinational).

Verification
REQ-031 SHALL test the table {CMD 0x0083, DATA 0x0002, DELAY 10000, CMD 0x0085, DATA 0x0003, END} with ack returned 2 cycles after each req: the bench sees writes (0,0x0083), (1,0x0002), one delay_step with delay_us=10000, then (0,0x0085), (1,0x0003), then done=1 and busy=0.
REQ-032 SHALL test DELAY arg=0: no delay_step is issued and the next entry's bus_req follows within 2 cycles.
REQ-033 SHALL test bus_ack held low for 100 cycles: bus_req, bus_rs and bus_data stay constant, and pc does not advance.
REQ-034 SHALL test rst pulsed during DLY_WAIT: all outputs are at reset values in the same cycle, and a later start restarts from entry 0.
REQ-035 SHALL test start pulsed while busy: no effect; after done, a second start clears done and replays the identical write trace.
REQ-036 SHALL test a table with no END: all 64 entries execute, then done=1, with no wrap to entry 0.
